// File: rtl/uart_pkg.sv
// Shared UART definitions: the transmit-handshake state encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/tx_hold_fifo.sv
// Small first-word-fall-through holding FIFO between CPU writes and the transmit handshake.
module tx_hold_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              cpu_clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              rd_en,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH):0]       count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // A write into a full FIFO is still taken when the head leaves on the same edge.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // NOTE: storage has no reset; empty/full come from count, so stale contents are never read.
    always_ff @(posedge cpu_clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_start_gen.sv
// CPU-side transmit handshake: buffers CPU write strobes and presents each byte as a level
// request to the transmitter core, returning a one-cycle tx_done per completed frame.
module tx_start_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                  cpu_clk,
    input  logic                  rst_n,
    input  logic                  cpu_wr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ready,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_overflow,
    output logic                  tx_timeout
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    tx_state_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tx_start_d;
    logic [DATA_WIDTH-1:0]   tx_data_d;
    logic                    tx_done_d;
    logic                    tx_timeout_d;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    tx_hold_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .cpu_clk (cpu_clk),
        .rst_n   (rst_n),
        .wr_en   (cpu_wr),
        .wr_data (cpu_wdata),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign cpu_ready = ~fifo_full;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_start_d   = tx_start;
        tx_data_d    = tx_data;
        tx_done_d    = 1'b0;
        tx_timeout_d = tx_timeout;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_data_d  = fifo_head;
                    tx_start_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = BUSY;
                end else if ((ACK_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    // No ack from the core: drop the byte without a tx_done.
                    tx_start_d   = 1'b0;
                    tx_timeout_d = 1'b1;
                    state_d      = IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUSY: begin
                if (!tx_busy) begin
                    tx_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            tx_done    <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_start   <= tx_start_d;
            tx_data    <= tx_data_d;
            tx_done    <= tx_done_d;
            tx_timeout <= tx_timeout_d;
        end
    end

    // Sticky until reset; a write into a full FIFO is only lost if the head is not leaving.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_overflow <= 1'b0;
        end else if (cpu_wr && fifo_full && !pop) begin
            tx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_start_gen.sv
// Scoreboard bench for tx_start_gen: stimulus queues expected bytes, a monitor checks each
// presented byte and the tx_start/tx_done handshake; a small core model drives tx_busy.
module tb_tx_start_gen;

    logic       cpu_clk;
    logic       rst_n;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic       cpu_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_overflow;
    logic       tx_timeout;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];

    bit         core_en    = 1'b1;
    int         busy_delay = 0;
    int         busy_len   = 8;

    tx_start_gen #(
        .DATA_WIDTH  (8),
        .FIFO_DEPTH  (4),
        .ACK_TIMEOUT (64)
    ) dut (
        .cpu_clk     (cpu_clk),
        .rst_n       (rst_n),
        .cpu_wr      (cpu_wr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_overflow (tx_overflow),
        .tx_timeout  (tx_timeout)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter core model: acknowledges a level request after busy_delay cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge cpu_clk);
            if (core_en && tx_start) begin
                repeat (busy_delay) @(negedge cpu_clk);
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge cpu_clk);
                tx_busy = 1'b0;
            end
        end
    end

    // Monitor: samples just after each active edge, inputs only change on the falling edge.
    initial begin
        logic       prev_start = 1'b0;
        logic       prev_done  = 1'b0;
        logic [7:0] prev_data  = '0;
        forever begin
            @(posedge cpu_clk);
            #1;
            if (rst_n) begin
                if (tx_start && !prev_start) begin
                    check("tx_start_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        check("tx_data", tx_data, exp_q.pop_front());
                    end
                end
                if (prev_start && tx_start) check("tx_data_stable", tx_data, prev_data);
                if (prev_start && tx_busy)  check("start_drop_on_busy", tx_start, 0);
                if (tx_done) begin
                    done_cnt++;
                    check("tx_done_single_cycle", prev_done, 0);
                end
            end
            prev_start = tx_start;
            prev_done  = tx_done;
            prev_data  = tx_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        cpu_wr = 1'b0;
        repeat (2) @(negedge cpu_clk);
        rst_n = 1'b1;
        @(negedge cpu_clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        cpu_wr    = 1'b1;
        cpu_wdata = b;
        @(negedge cpu_clk);
        cpu_wr    = 1'b0;
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!tx_busy && n < budget) begin
            @(negedge cpu_clk);
            n++;
        end
        check("wait_tx_busy", tx_busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!tx_done && n < budget) begin
            @(negedge cpu_clk);
            n++;
        end
        check("wait_tx_done", tx_done, 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || tx_start || tx_busy) && n < budget) begin
            @(negedge cpu_clk);
            n++;
        end
        repeat (4) @(negedge cpu_clk);
        check("drain_in_budget", 32'(n < budget), 1);
    endtask

    initial begin
        int cnt;
        rst_n     = 1'b0;
        cpu_wr    = 1'b0;
        cpu_wdata = '0;
        @(negedge cpu_clk);
        check("rst_cpu_ready", cpu_ready, 1);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_flags", {tx_overflow, tx_timeout}, 0);
        @(negedge cpu_clk);
        rst_n = 1'b1;
        @(negedge cpu_clk);

        // 1: single byte, core acknowledges two cycles after tx_start
        done_cnt = 0; busy_delay = 2; busy_len = 10;
        exp_q.push_back(8'hA5);
        write_byte(8'hA5);
        check("t1_start_not_yet", tx_start, 0);
        @(negedge cpu_clk);
        check("t1_start_latency", tx_start, 1);
        check("t1_data", tx_data, 8'hA5);
        drain(100);
        check("t1_done_count", done_cnt, 1);
        check("t1_overflow", tx_overflow, 0);

        // 2: four back-to-back writes
        done_cnt = 0; busy_delay = 0; busy_len = 8;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            cpu_wr = 1'b1; cpu_wdata = 8'(i);
            @(negedge cpu_clk);
        end
        cpu_wr = 1'b0;
        check("t2_ready_three_held", cpu_ready, 1);
        drain(200);
        check("t2_done_count", done_cnt, 4);

        // 3: six writes while the first frame is busy, the last two are dropped
        done_cnt = 0; busy_len = 20;
        exp_q.push_back(8'h10);
        write_byte(8'h10);
        wait_busy(20);
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) exp_q.push_back(8'(8'h10 + i));
            cpu_wr = 1'b1; cpu_wdata = 8'(8'h10 + i);
            @(negedge cpu_clk);
            if (i == 4) check("t3_ready_full", cpu_ready, 0);
        end
        cpu_wr = 1'b0;
        check("t3_ready_still_full", cpu_ready, 0);
        check("t3_overflow", tx_overflow, 1);
        drain(500);
        check("t3_done_count", done_cnt, 5);
        check("t3_ready_after", cpu_ready, 1);

        // 4: no ack from the core -> timeout after 64 cycles in START
        do_reset();
        done_cnt = 0; core_en = 1'b0; busy_len = 5;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5B);
        cpu_wr = 1'b1; cpu_wdata = 8'h5A; @(negedge cpu_clk);
        cpu_wdata = 8'h5B; @(negedge cpu_clk);
        cpu_wr = 1'b0;
        cnt = 0;
        while (tx_start && cnt < 200) begin
            @(negedge cpu_clk);
            cnt++;
        end
        check("t4_start_cycles", cnt, 64);
        check("t4_timeout", tx_timeout, 1);
        check("t4_no_done", done_cnt, 0);
        core_en = 1'b1;
        drain(100);
        check("t4_done_next_byte", done_cnt, 1);

        // 5: write while full coincides with the pop
        do_reset();
        done_cnt = 0; busy_len = 12;
        exp_q.push_back(8'h20);
        write_byte(8'h20);
        wait_busy(20);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(8'h20 + i));
            cpu_wr = 1'b1; cpu_wdata = 8'(8'h20 + i);
            @(negedge cpu_clk);
        end
        cpu_wr = 1'b0;
        check("t5_full_before", cpu_ready, 0);
        wait_done(40);
        exp_q.push_back(8'h25);
        write_byte(8'h25);
        check("t5_no_overflow", tx_overflow, 0);
        check("t5_full_after", cpu_ready, 0);
        drain(500);
        check("t5_done_count", done_cnt, 6);

        // 6: reset mid-BUSY with two bytes buffered
        done_cnt = 0; busy_len = 30;
        exp_q.push_back(8'h30);
        write_byte(8'h30);
        wait_busy(20);
        write_byte(8'h31);
        write_byte(8'h32);
        @(negedge cpu_clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_outputs", {tx_start, tx_done, tx_overflow, tx_timeout}, 0);
        check("t6_async_data", tx_data, 0);
        check("t6_async_ready", cpu_ready, 1);
        @(negedge cpu_clk);
        rst_n = 1'b1;
        repeat (40) @(negedge cpu_clk);
        check("t6_idle_after_reset", tx_start, 0);
        check("t6_no_done_after_reset", done_cnt, 0);
        exp_q.push_back(8'h33);
        write_byte(8'h33);
        drain(100);
        check("t6_done_new_byte", done_cnt, 1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
